dual_stream_framer: RTL and testbench
=====================================

Name: dual_stream_framer

Overview:
- Sits directly downstream of the 64-bit-to-dual-32-bit stream splitter.
- Re-joins the paired sample streams into 64-bit words and tags frame boundaries.
- Delivers words on a backpressured valid/ready master interface through an internal FIFO.
- The splitter cannot be stalled, so this block absorbs downstream stalls and counts losses: FIFO-full drops and lane misalignment.

Parameters:
- FRAME_LEN, default 4448: samples per frame (ACTIVE 3276 + IDLE 1172); m_last is asserted on the final sample of each frame.
- FIFO_ADDR_WIDTH, default 10: FIFO depth is 2**FIFO_ADDR_WIDTH entries.
- CNT_WIDTH, default 16: width of the saturating error counters.

Ports:
- clk  in  1: single clock; all logic on posedge.
- rst_n  in  1: reset, asynchronous assert, active-low.
- data_port1  in  32: lane 1 sample (upper half of the original word).
- valid1  in  1: lane 1 sample valid.
- data_port2  in  32: lane 2 sample (lower half).
- valid2  in  1: lane 2 sample valid.
- m_data  out  64: {lane1, lane2} output word.
- m_valid  out  1: m_data/m_last valid.
- m_ready  in  1: downstream ready.
- m_last  out  1: last word of frame.
- fifo_level  out  FIFO_ADDR_WIDTH+1: current FIFO occupancy.
- overflow_cnt  out  CNT_WIDTH: aligned samples dropped because the FIFO was full; saturating.
- misalign_cnt  out  CNT_WIDTH: cycles with valid1 != valid2; saturating.
- misalign_flag  out  1: sticky, set on the first misalignment, cleared only by reset.

Behaviour:
- Reset (async, rst_n=0):
  - sample_cnt=0, FIFO pointers=0, fifo_level=0.
  - m_valid=0, m_last=0, m_data=0.
  - Both counters=0, misalign_flag=0.
  - Reset mid-frame discards FIFO contents; framing restarts at sample 0.
- Input qualification, each cycle:
  - valid1&valid2: aligned sample.
  - valid1^valid2: misaligned. Nothing is pushed, sample_cnt is unchanged, misalign_cnt increments, misalign_flag is set.
  - Neither valid: idle; no state change.
- Framing:
  - Every aligned sample advances sample_cnt, whether or not it is stored.
  - At sample_cnt==FRAME_LEN-1 the tag last=1 and sample_cnt wraps to 0; otherwise last=0 and sample_cnt increments.
  - Framing therefore stays locked to the input timeline even across drops.
- Push:
  - Entry {last, data_port1, data_port2}, 65 bits, is written when the sample is aligned and (!full or pop this cycle).
  - Push onto a full FIFO with a simultaneous pop is accepted.
  - Push onto a full FIFO without a pop is dropped and overflow_cnt increments.
  - A dropped last sample loses its tag; the next frame still begins at sample_cnt 0.
- Pop:
  - pop = m_valid & m_ready.
  - The output is first-word-fall-through: m_valid = !empty, with m_data/m_last showing the head entry.
  - m_data/m_last are held stable while m_valid & !m_ready.
- Latency: an aligned sample at input cycle N into an empty FIFO appears with m_valid=1 at cycle N+1.
- Throughput: 1 word/cycle sustained when m_ready=1.
- fifo_level:
  - +1 on push only, -1 on pop only, unchanged on both or neither.
  - Range 0..2**FIFO_ADDR_WIDTH.
  - Full is fifo_level==depth; empty is fifo_level==0.
- Pointers: binary, wrap modulo depth.
- Counters: saturate at all-ones; no wrap.
- Simultaneous misalignment and pop: the pop proceeds normally.

Decomposition:
- Package stream_pkg:
  - SAMPLE_W=32.
  - Packed struct frame_word_t {logic last; logic [31:0] lane1; logic [31:0] lane2;}.
  - Default FRAME_LEN constant 4448.
- Sub-module sync_fifo_fwft:
  - Parameterised width/addr width; push/pop/full/empty/level; FWFT read.
  - Holds all storage and pointers.
- Top level owns qualification, framing counter, drop logic and error counters.

Test Plan (FRAME_LEN=8, FIFO_ADDR_WIDTH=3 unless stated):
- Continuous aligned input 0..23 with m_ready=1 -> outputs 0..23 in order, each one cycle after input; m_last on samples 7, 15, 23; fifo_level never exceeds 1.
- m_ready=0 while 12 aligned samples arrive -> fifo_level reaches 8, overflow_cnt=4. Then m_ready=1 -> outputs samples 0..7; m_last only on sample 7; next frame's sample 0 is input sample 8+... per sample_cnt.
- FIFO full with m_ready=1 and an aligned push in the same cycle -> push accepted, fifo_level stays 8, overflow_cnt unchanged.
- Drive valid1=1, valid2=0 for 3 cycles between aligned samples 2 and 3 -> misalign_cnt=3, misalign_flag=1; m_last still lands on the 8th aligned sample.
- Assert rst_n=0 asynchronously mid-clock with 5 entries queued at sample_cnt=5 -> m_valid drops immediately, fifo_level=0, counters=0. The next aligned sample is frame sample 0, and m_last falls on the 8th sample after reset.
- Force overflow_cnt to saturate (CNT_WIDTH=4, 20 drops) -> overflow_cnt holds at 15.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared types and constants for the dual-stream framer.
//
// SAMPLE_W          : width of one lane sample
// DEFAULT_FRAME_LEN : samples per frame (3276 active + 1172 idle)
// frame_word_t      : one FIFO entry, {last, lane1, lane2}
package stream_pkg;

    localparam int SAMPLE_W          = 32;
    localparam int DEFAULT_FRAME_LEN = 4448;

    typedef struct packed {
        logic                last;
        logic [SAMPLE_W-1:0] lane1;
        logic [SAMPLE_W-1:0] lane2;
    } frame_word_t;

    localparam int FRAME_WORD_W = $bits(frame_word_t);

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO.
//
// Ports:
//   clk, rst_n : clock, async active-low reset (pointers and level only)
//   push       : write wr_data; accepted when not full, or when full with pop
//   wr_data    : entry to write
//   pop        : consume the head entry; ignored when empty
//   rd_data    : head entry, valid whenever empty is low
//   full/empty : occupancy flags
//   level      : occupancy, 0..2**ADDR_W
module sync_fifo_fwft #(
    parameter int WIDTH  = 65,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              pop,
    output logic [WIDTH-1:0]  rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign full    = (level == (ADDR_W+1)'(DEPTH));
    assign empty   = (level == '0);
    assign rd_data = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; emptiness is tracked by level, so
    // stale contents are never visible and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/dual_stream_framer.sv
// Re-joins the two 32-bit lanes from the stream splitter into 64-bit words,
// tags the last sample of each frame, and buffers words for a backpressured
// valid/ready consumer. The splitter cannot stall, so FIFO-full drops and
// lane misalignment are counted instead.
//
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   data_port1, valid1  : lane 1 sample (upper half of output word)
//   data_port2, valid2  : lane 2 sample (lower half of output word)
//   m_data, m_valid,
//   m_ready, m_last     : FWFT master interface, m_last on the final frame sample
//   fifo_level          : current FIFO occupancy
//   overflow_cnt        : aligned samples dropped on a full FIFO (saturating)
//   misalign_cnt        : cycles with valid1 != valid2 (saturating)
//   misalign_flag       : sticky misalignment indicator
module dual_stream_framer
    import stream_pkg::*;
#(
    parameter int FRAME_LEN       = DEFAULT_FRAME_LEN,
    parameter int FIFO_ADDR_WIDTH = 10,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SAMPLE_W-1:0]      data_port1,
    input  logic                     valid1,
    input  logic [SAMPLE_W-1:0]      data_port2,
    input  logic                     valid2,
    output logic [2*SAMPLE_W-1:0]    m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last,
    output logic [FIFO_ADDR_WIDTH:0] fifo_level,
    output logic [CNT_WIDTH-1:0]     overflow_cnt,
    output logic [CNT_WIDTH-1:0]     misalign_cnt,
    output logic                     misalign_flag
);

    localparam int SCNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic [SCNT_W-1:0] sample_cnt;
    logic              aligned;
    logic              misaligned;
    logic              last_tag;
    logic              pop;
    logic              full;
    logic              empty;
    logic              drop;
    frame_word_t       wr_word;
    frame_word_t       head;

    assign aligned    = valid1 & valid2;
    assign misaligned = valid1 ^ valid2;
    assign last_tag   = (sample_cnt == SCNT_W'(FRAME_LEN - 1));

    assign m_valid = ~empty;
    assign pop     = m_valid & m_ready;
    // A dropped sample still consumed its frame slot; only storage is lost.
    assign drop    = aligned & full & ~pop;

    assign wr_word = '{last: last_tag, lane1: data_port1, lane2: data_port2};

    // Head is gated so the bus reads zero, not stale RAM, while nothing is queued.
    assign m_data  = m_valid ? {head.lane1, head.lane2} : '0;
    assign m_last  = m_valid & head.last;

    sync_fifo_fwft #(
        .WIDTH  (FRAME_WORD_W),
        .ADDR_W (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (aligned),
        .wr_data (wr_word),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    // Framing follows the input timeline: every aligned sample advances the
    // counter whether or not the FIFO accepted it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
        end else if (aligned) begin
            sample_cnt <= last_tag ? '0 : sample_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_cnt  <= '0;
            misalign_cnt  <= '0;
            misalign_flag <= 1'b0;
        end else begin
            if (drop && overflow_cnt != '1)
                overflow_cnt <= overflow_cnt + 1'b1;
            if (misaligned) begin
                misalign_flag <= 1'b1;
                if (misalign_cnt != '1)
                    misalign_cnt <= misalign_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dual_stream_framer.sv
// Self-checking bench for dual_stream_framer (FRAME_LEN=8, depth 8, 4-bit counters).
// A queue-based reference model tracks the buffered words; every cycle the
// DUT outputs are compared against it, with table-driven and directed
// sequences for the corner cases and a randomized soak at the end.
module tb_dual_stream_framer;

    localparam int FRAME_LEN = 8;
    localparam int AW        = 3;
    localparam int CW        = 4;
    localparam int DEPTH     = 1 << AW;
    localparam int CNT_MAX   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   data_port1 = '0;
    logic [31:0]   data_port2 = '0;
    logic          valid1 = 1'b0;
    logic          valid2 = 1'b0;
    logic [63:0]   m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;
    logic [AW:0]   fifo_level;
    logic [CW-1:0] overflow_cnt;
    logic [CW-1:0] misalign_cnt;
    logic          misalign_flag;

    dual_stream_framer #(
        .FRAME_LEN       (FRAME_LEN),
        .FIFO_ADDR_WIDTH (AW),
        .CNT_WIDTH       (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_port1    (data_port1),
        .valid1        (valid1),
        .data_port2    (data_port2),
        .valid2        (valid2),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .fifo_level    (fifo_level),
        .overflow_cnt  (overflow_cnt),
        .misalign_cnt  (misalign_cnt),
        .misalign_flag (misalign_flag)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        bit          last;
        logic [63:0] data;
    } entry_t;

    entry_t q[$];
    int     frame_pos;   // index of the next aligned sample within its frame
    int     m_ovf;
    int     m_mis;
    bit     m_flag;
    int     sample_no;   // running tag for directed data

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        frame_pos = 0;
        m_ovf     = 0;
        m_mis     = 0;
        m_flag    = 0;
    endtask

    task automatic compare_all();
        check("m_valid", 64'(m_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            check("m_data", m_data, q[0].data);
            check("m_last", 64'(m_last), 64'(q[0].last));
        end else begin
            check("m_data_idle", m_data, 64'd0);
            check("m_last_idle", 64'(m_last), 64'd0);
        end
        check("fifo_level", 64'(fifo_level), 64'(q.size()));
        check("overflow_cnt", 64'(overflow_cnt), 64'(m_ovf));
        check("misalign_cnt", 64'(misalign_cnt), 64'(m_mis));
        check("misalign_flag", 64'(misalign_flag), 64'(m_flag));
    endtask

    // One clock cycle: inputs applied after a falling edge, outputs checked 1 ns
    // after the following rising edge.
    task automatic drive(input logic v1, input logic v2, input logic rdy,
                         input logic [31:0] d1, input logic [31:0] d2);
        int     pre;
        bit     popped;
        entry_t e;
        valid1     = v1;
        valid2     = v2;
        m_ready    = rdy;
        data_port1 = d1;
        data_port2 = d2;
        pre    = q.size();
        popped = rdy && (pre > 0);
        @(posedge clk);
        #1;
        if (popped)
            void'(q.pop_front());
        if (v1 && v2) begin
            e.last    = (frame_pos == FRAME_LEN - 1);
            e.data    = {d1, d2};
            frame_pos = (frame_pos + 1) % FRAME_LEN;
            if (pre < DEPTH || popped)
                q.push_back(e);
            else if (m_ovf < CNT_MAX)
                m_ovf++;
        end else if (v1 != v2) begin
            m_flag = 1;
            if (m_mis < CNT_MAX)
                m_mis++;
        end
        compare_all();
        @(negedge clk);
    endtask

    task automatic aligned_sample(input logic rdy);
        drive(1'b1, 1'b1, rdy, 32'hA500_0000 | 32'(sample_no), 32'h0000_5A00 + 32'(sample_no));
        sample_no++;
    endtask

    // Asserts reset away from any clock edge and checks the reset state at once.
    task automatic do_reset();
        valid1  = 1'b0;
        valid2  = 1'b0;
        m_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- table-driven overflow sequence ----------------
    typedef struct {
        logic v1;
        logic v2;
        logic rdy;
        int   exp_level;
        int   exp_ovf;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input logic v1, input logic v2, input logic rdy,
                                input int lvl, input int ovf);
        vec_t v;
        v.v1 = v1; v.v2 = v2; v.rdy = rdy; v.exp_level = lvl; v.exp_ovf = ovf;
        return v;
    endfunction

    initial begin
        // 12 aligned samples into a stalled output: fills to 8, then 4 drops.
        vecs[0]  = mk(1, 1, 0, 1, 0);
        vecs[1]  = mk(1, 1, 0, 2, 0);
        vecs[2]  = mk(1, 1, 0, 3, 0);
        vecs[3]  = mk(1, 1, 0, 4, 0);
        vecs[4]  = mk(1, 1, 0, 5, 0);
        vecs[5]  = mk(1, 1, 0, 6, 0);
        vecs[6]  = mk(1, 1, 0, 7, 0);
        vecs[7]  = mk(1, 1, 0, 8, 0);
        vecs[8]  = mk(1, 1, 0, 8, 1);
        vecs[9]  = mk(1, 1, 0, 8, 2);
        vecs[10] = mk(1, 1, 0, 8, 3);
        vecs[11] = mk(1, 1, 0, 8, 4);
        // Full FIFO, push and pop together: accepted, no drop.
        vecs[12] = mk(1, 1, 1, 8, 4);
        // Drain.
        vecs[13] = mk(0, 0, 1, 7, 4);
        vecs[14] = mk(0, 0, 1, 6, 4);
        vecs[15] = mk(0, 0, 1, 5, 4);
        vecs[16] = mk(0, 0, 1, 4, 4);
        vecs[17] = mk(0, 0, 1, 3, 4);
        vecs[18] = mk(0, 0, 1, 2, 4);
        vecs[19] = mk(0, 0, 1, 1, 4);
        vecs[20] = mk(0, 0, 1, 0, 4);

        model_clear();
        sample_no = 0;
        @(negedge clk);
        do_reset();

        // Continuous aligned input with m_ready=1: one word per cycle, level <= 1.
        for (int i = 0; i < 24; i++) begin
            aligned_sample(1'b1);
            if (fifo_level > 1)
                check("level_bound", 64'(fifo_level), 64'd1);
        end

        // Overflow table.
        do_reset();
        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].v1, vecs[i].v2, vecs[i].rdy,
                  32'hC000_0000 | 32'(i), 32'h0000_0C00 + 32'(i));
            check("tbl_level", 64'(fifo_level), 64'(vecs[i].exp_level));
            check("tbl_ovf", 64'(overflow_cnt), 64'(vecs[i].exp_ovf));
        end

        // Misalignment between aligned samples 2 and 3; last still on the 8th.
        do_reset();
        for (int i = 0; i < 3; i++) aligned_sample(1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 32'hDEAD_0000, 32'h0);
        check("mis_cnt3", 64'(misalign_cnt), 64'd3);
        check("mis_flag", 64'(misalign_flag), 64'd1);
        for (int i = 0; i < 5; i++) begin
            aligned_sample(1'b1);
            check("mis_last", 64'(m_last), 64'(i == 4));
        end

        // Asynchronous reset with 5 queued at sample_cnt=5.
        do_reset();
        for (int i = 0; i < 5; i++) aligned_sample(1'b0);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        do_reset();
        check("rst_valid", 64'(m_valid), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        for (int i = 0; i < 8; i++) begin
            aligned_sample(1'b1);
            check("rst_last", 64'(m_last), 64'(i == 7));
        end

        // Saturation: 8 stored, 20 dropped -> counter pinned at 15.
        do_reset();
        for (int i = 0; i < 28; i++) aligned_sample(1'b0);
        check("ovf_sat", 64'(overflow_cnt), 64'(CNT_MAX));

        // Randomized soak against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int  sel;
            logic rdy;
            sel = int'($urandom_range(0, 9));
            rdy = ((i / 40) % 3 == 1) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
            if (sel <= 5)
                drive(1'b1, 1'b1, rdy, $urandom, $urandom);
            else if (sel == 6)
                drive(1'b1, 1'b0, rdy, $urandom, $urandom);
            else if (sel == 7)
                drive(1'b0, 1'b1, rdy, $urandom, $urandom);
            else
                drive(1'b0, 1'b0, rdy, $urandom, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
